// File: rtl/ula_op_scheduler_pkg.sv
// Shared types and constants for the ULA operation scheduler.
// The opcode constants name the eight decoder select lines.
package ula_op_scheduler_pkg;

    localparam int unsigned OP_W        = 3;
    localparam int unsigned LAT_DEFAULT = 2;

    localparam logic [OP_W-1:0] OpAdd = 3'd0;
    localparam logic [OP_W-1:0] OpSub = 3'd1;
    localparam logic [OP_W-1:0] OpAnd = 3'd2;
    localparam logic [OP_W-1:0] OpOr  = 3'd3;
    localparam logic [OP_W-1:0] OpXor = 3'd4;
    localparam logic [OP_W-1:0] OpNot = 3'd5;
    localparam logic [OP_W-1:0] OpShl = 3'd6;
    localparam logic [OP_W-1:0] OpShr = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

endpackage

// File: rtl/ula_op_scheduler_if.sv
// Requester/decoder bundle of the scheduler; the scheduler is the slave,
// the requester/decoder side is the master.
interface ula_op_scheduler_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned OP_W  = 3
);
    logic [N_REQ-1:0]      req;
    logic [N_REQ*OP_W-1:0] op;
    logic [N_REQ-1:0]      gnt;
    logic [OP_W-1:0]       dec_a;
    logic                  dec_en;
    logic [N_REQ-1:0]      done;
    logic                  busy;

    modport master (
        output req, op,
        input  gnt, dec_a, dec_en, done, busy
    );

    modport slave (
        input  req, op,
        output gnt, dec_a, dec_en, done, busy
    );
endinterface

// File: rtl/ula_op_scheduler_rr_picker.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ...
// modulo N_REQ, returned as one-hot, as an index and with a valid flag.
module ula_op_scheduler_rr_picker #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] win_o,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             valid_o
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] idx;
        found     = 1'b0;
        idx       = '0;
        win_o     = '0;
        win_idx_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = IDX_W'((32'(ptr_i) + 32'(k)) % N_REQ);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                win_o[idx] = 1'b1;
                win_idx_o  = idx;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/ula_op_scheduler.sv
// Round-robin scheduler sharing the ULA decoder between N_REQ requesters.
// Grants one requester, drives dec_a/dec_en for LAT cycles, then pulses done.
module ula_op_scheduler
    import ula_op_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LAT   = LAT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    ula_op_scheduler_if.slave  bus
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT + 1) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] win_idx_q, win_idx_d;
    logic [N_REQ-1:0] win_q, win_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [OP_W-1:0]  dec_a_q, dec_a_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             dec_en_q, dec_en_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] pick_win;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [IDX_W-1:0] next_ptr;

    ula_op_scheduler_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req_i     (bus.req),
        .ptr_i     (ptr_q),
        .win_o     (pick_win),
        .win_idx_o (pick_idx),
        .valid_o   (pick_valid)
    );

    assign next_ptr = (win_idx_q == IDX_W'(N_REQ - 1)) ? '0 : win_idx_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            win_idx_q <= '0;
            win_q     <= '0;
            ptr_q     <= '0;
            dec_a_q   <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            dec_en_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_idx_q <= win_idx_d;
            win_q     <= win_d;
            ptr_q     <= ptr_d;
            dec_a_q   <= dec_a_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            dec_en_q  <= dec_en_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_idx_d = win_idx_q;
        win_d     = win_q;
        ptr_d     = ptr_q;
        dec_a_d   = dec_a_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d   = StExec;
                    win_idx_d = pick_idx;
                    win_d     = pick_win;
                    dec_a_d   = bus.op[int'(pick_idx)*OP_W +: OP_W];
                    cnt_d     = CNT_W'(LAT - 1);
                end
            end
            StExec: begin
                // Abort wins over completion when both happen in the same cycle.
                if (!bus.req[win_idx_q]) begin
                    state_d = StIdle;
                    ptr_d   = next_ptr;
                end else if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                ptr_d   = next_ptr;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed from the next state so that they come straight from flops.
    always_comb begin
        gnt_d    = (state_d == StExec) ? win_d : '0;
        done_d   = (state_d == StDone) ? win_d : '0;
        dec_en_d = (state_d == StExec);
        busy_d   = (state_d != StIdle);
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.dec_a  = dec_a_q;
    assign bus.dec_en = dec_en_q;
    assign bus.busy   = busy_q;

endmodule
